// File: rtl/ldd_pkg.sv
// Shared types and default sizes for the laser-driver write-disable scheduler.
package ldd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StGuard
  } ch_state_e;

  localparam int unsigned CntWDefault       = 16;
  localparam int unsigned StaggerCycDefault = 8;

endpackage

// File: rtl/ldd_ch_fsm.sv
// One write-disable channel: IDLE -> ON -> GUARD -> IDLE, with a guard-time down-counter.
module ldd_ch_fsm
  import ldd_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk200,
  input  logic             rst,
  input  logic             hit,
  input  logic             on,
  input  logic [CNT_W-1:0] guard_cyc,
  output logic             wdis,
  output logic             in_guard
);

  ch_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wdis_q;

  always_ff @(posedge clk200) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wdis_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (hit && on) begin
            state_q <= StOn;
            wdis_q  <= 1'b1;
          end
        end
        StOn: begin
          if (hit && !on) begin
            wdis_q <= 1'b0;
            if (guard_cyc == '0) begin
              state_q <= StIdle;
            end else begin
              // Counter holds cycles remaining after the current one.
              state_q <= StGuard;
              cnt_q   <= guard_cyc - CNT_W'(1);
            end
          end
        end
        StGuard: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          wdis_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wdis     = wdis_q;
  assign in_guard = (state_q == StGuard);

endmodule

// File: rtl/ldd_wdis_sched.sv
// Laser-driver write-disable scheduler: per-channel command FSMs plus a capture window.
// Define LDD_STAGGER_EN to offset each channel's capture window by STAGGER_CYC cycles.
module ldd_wdis_sched
  import ldd_pkg::*;
#(
  parameter int unsigned CH_NUM      = 3,
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned STAGGER_CYC = StaggerCycDefault,
  localparam int unsigned CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk200,
  input  logic              rst,
  input  logic              cap_mode,
  input  logic              cap_trig,
  input  logic [CNT_W-1:0]  cap_len,
  input  logic [CNT_W-1:0]  guard_cyc,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic              cmd_on,
  output logic [CH_NUM-1:0] com_wdis,
  output logic [CH_NUM-1:0] cap_wdis,
  output logic              cap_busy,
  output logic              cap_done,
  output logic              cmd_err
);

`ifdef LDD_STAGGER_EN
  localparam int unsigned Ofs = STAGGER_CYC;
`else
  localparam int unsigned Ofs = 0;
`endif
  localparam int unsigned LastOfs = (CH_NUM - 1) * Ofs;
  // Wide enough for the longest window plus the largest stagger offset.
  localparam int unsigned SpanW   = CNT_W + $clog2((CH_NUM - 1) * STAGGER_CYC + 2);

  // Command path
  logic [CH_NUM-1:0] ch_wdis;
  logic [CH_NUM-1:0] ch_guard;
  logic [CH_NUM-1:0] ch_hit;
  logic              ch_valid;
  logic              sel_guard;
  logic              accept;
  logic              cmd_err_q;

  always_comb begin
    ch_valid  = ({1'b0, cmd_ch} < (CH_W + 1)'(CH_NUM));
    sel_guard = 1'b0;
    for (int k = 0; k < int'(CH_NUM); k++) begin
      if (cmd_ch == CH_W'(k) && ch_guard[k]) sel_guard = 1'b1;
    end
    // Only re-enabling a channel that is still in its guard time is stalled.
    cmd_ready = ~rst & ~(cmd_valid & cmd_on & sel_guard);
    accept    = cmd_valid & cmd_ready;
    for (int k = 0; k < int'(CH_NUM); k++) begin
      ch_hit[k] = accept & (cmd_ch == CH_W'(k));
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    ldd_ch_fsm #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk200    (clk200),
      .rst       (rst),
      .hit       (ch_hit[k]),
      .on        (cmd_on),
      .guard_cyc (guard_cyc),
      .wdis      (ch_wdis[k]),
      .in_guard  (ch_guard[k])
    );
  end

  always_ff @(posedge clk200) begin
    if (rst) begin
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= accept & ~ch_valid;
    end
  end

  // Capture path: one elapsed counter, each channel windowed at its own offset
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SpanW-1:0] elapsed_q, elapsed_d;
  logic [SpanW-1:0] last_cyc;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CH_NUM-1:0] cap_wdis_q, cap_wdis_d;

  assign last_cyc = SpanW'(len_q) + SpanW'(LastOfs) - SpanW'(1);

  always_comb begin
    busy_d    = busy_q;
    done_d    = 1'b0;
    elapsed_d = elapsed_q;
    len_d     = len_q;
    if (busy_q) begin
      if (!cap_mode) begin
        busy_d = 1'b0;
      end else if (elapsed_q == last_cyc) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        elapsed_d = elapsed_q + SpanW'(1);
      end
    end else if (cap_trig && cap_mode) begin
      busy_d    = 1'b1;
      elapsed_d = '0;
      len_d     = (cap_len == '0) ? CNT_W'(1) : cap_len;
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_win
    logic [SpanW:0] rel;
    // Borrow bit set means the window for this channel has not opened yet.
    assign rel           = {1'b0, elapsed_d} - (SpanW + 1)'(k * Ofs);
    assign cap_wdis_d[k] = busy_d & ~rel[SpanW] & (rel[SpanW-1:0] < SpanW'(len_d));
  end

  always_ff @(posedge clk200) begin
    if (rst) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      elapsed_q  <= '0;
      len_q      <= '0;
      cap_wdis_q <= '0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      elapsed_q  <= elapsed_d;
      len_q      <= len_d;
      cap_wdis_q <= cap_wdis_d;
    end
  end

  assign com_wdis = ch_wdis;
  assign cap_wdis = cap_wdis_q;
  assign cap_busy = busy_q;
  assign cap_done = done_q;
  assign cmd_err  = cmd_err_q;

endmodule
